// File: rtl/serial_bit_feeder_pkg.sv
// Shared definitions for the serial bit feeder: FSM state encoding and
// parameter range limits used to size the internal counters.
package serial_bit_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } feeder_state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;
    localparam int GAP_MIN   = 0;
    localparam int GAP_MAX   = 15;

    // Counter widths cover the full legal parameter ranges.
    localparam int BIT_CNT_W = $clog2(WIDTH_MAX);
    localparam int GAP_CNT_W = $clog2(GAP_MAX + 1);

endpackage

// File: rtl/serial_bit_feeder_if.sv
// Upstream parallel-word handshake into the serial bit feeder.
interface serial_bit_feeder_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;

    modport master (output din, output din_valid, input din_ready);
    modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/serial_bit_feeder_shift_reg.sv
// Parallel-load, one-bit-per-cycle shift register; the serial output is the
// bit at the end the word leaves from (MSB or LSB).
module serial_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] din,
    output logic             dout
);
    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] data_shifted;

    // Each bit takes its neighbour on the far side from the output end.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        if (MSB_FIRST) begin : g_msb
            if (gi == 0) begin : g_end
                assign data_shifted[gi] = 1'b0;
            end else begin : g_mid
                assign data_shifted[gi] = data_reg[gi-1];
            end
        end else begin : g_lsb
            if (gi == WIDTH - 1) begin : g_end
                assign data_shifted[gi] = 1'b0;
            end else begin : g_mid
                assign data_shifted[gi] = data_reg[gi+1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            data_reg <= '0;
        end else if (load) begin
            data_reg <= din;
        end else if (shift_en) begin
            data_reg <= data_shifted;
        end
    end

    assign dout = MSB_FIRST ? data_reg[WIDTH-1] : data_reg[0];

endmodule

// File: rtl/serial_bit_feeder.sv
// Serializes parallel words into a 1-bit stream with optional idle gaps
// between words; a one-word holding register decouples the upstream source.
module serial_bit_feeder
    import serial_bit_feeder_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int GAP       = 0,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    serial_bit_feeder_if.slave  up,
    output logic                X,
    output logic                x_valid,
    output logic                busy,
    output logic [7:0]          words_sent
);
    feeder_state_t        state_reg, state_next;
    logic [WIDTH-1:0]     hold_reg;
    logic                 hold_full_reg;
    logic [BIT_CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
    logic [GAP_CNT_W-1:0] gap_cnt_reg, gap_cnt_next;
    logic [7:0]           words_sent_reg;
    logic                 accept;
    logic                 load;
    logic                 shift_en;
    logic                 hold_clear;
    logic                 sent_inc;
    logic                 shift_out;

    // din_ready comes straight from the hold flag, so accept never races a reload.
    assign accept       = up.din_valid && !hold_full_reg;
    assign up.din_ready = !hold_full_reg;

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        gap_cnt_next = gap_cnt_reg;
        load         = 1'b0;
        shift_en     = 1'b0;
        hold_clear   = 1'b0;
        sent_inc     = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (hold_full_reg) begin
                    load         = 1'b1;
                    hold_clear   = 1'b1;
                    bit_cnt_next = '0;
                    state_next   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_en     = 1'b1;
                bit_cnt_next = bit_cnt_reg + BIT_CNT_W'(1);
                if (bit_cnt_reg == BIT_CNT_W'(WIDTH - 1)) begin
                    sent_inc = 1'b1;
                    if (GAP > 0) begin
                        gap_cnt_next = '0;
                        state_next   = ST_GAP;
                    end else if (hold_full_reg) begin
                        load         = 1'b1;
                        hold_clear   = 1'b1;
                        bit_cnt_next = '0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                gap_cnt_next = gap_cnt_reg + GAP_CNT_W'(1);
                if (gap_cnt_reg == GAP_CNT_W'(GAP - 1)) begin
                    if (hold_full_reg) begin
                        load         = 1'b1;
                        hold_clear   = 1'b1;
                        bit_cnt_next = '0;
                        state_next   = ST_SHIFT;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            hold_reg       <= '0;
            hold_full_reg  <= 1'b0;
            bit_cnt_reg    <= '0;
            gap_cnt_reg    <= '0;
            words_sent_reg <= '0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            gap_cnt_reg <= gap_cnt_next;
            if (accept) begin
                hold_reg      <= up.din;
                hold_full_reg <= 1'b1;
            end else if (hold_clear) begin
                hold_full_reg <= 1'b0;
            end
            if (sent_inc) begin
                words_sent_reg <= words_sent_reg + 8'd1;
            end
        end
    end

    serial_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk      (clk),
        .srst     (rst),
        .load     (load),
        .shift_en (shift_en),
        .din      (hold_reg),
        .dout     (shift_out)
    );

    assign x_valid    = (state_reg == ST_SHIFT);
    assign X          = x_valid & shift_out;
    assign busy       = (state_reg != ST_IDLE) || hold_full_reg;
    assign words_sent = words_sent_reg;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: three instances (GAP=0 MSB-first, GAP=2
// MSB-first, GAP=0 LSB-first) checked every cycle against a slot-schedule model.
module tb_serial_bit_feeder;
    import serial_bit_feeder_pkg::*;

    localparam int W  = 8;
    localparam int NI = 3;
    localparam int GAPS [NI] = '{0, 2, 0};
    localparam bit MSBF [NI] = '{1'b1, 1'b1, 1'b0};

    typedef struct {
        bit x;
        bit v;
        bit first;
        bit last;
    } slot_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din_a  [NI];
    logic         dv_a   [NI];
    logic         rdy    [NI];
    logic         x_o    [NI];
    logic         xv_o   [NI];
    logic         busy_o [NI];
    logic [7:0]   ws_o   [NI];

    // Model: each queue entry is what the output must show in one future cycle.
    slot_t      mq   [NI][$];
    logic [7:0] ws_m [NI];
    bit         logb [NI][$];
    int         logc [NI][$];
    int         cyc;
    int         total;
    int         bad;

    always #5 clk = ~clk;

    serial_bit_feeder_if #(.WIDTH(W)) bus0 ();
    serial_bit_feeder_if #(.WIDTH(W)) bus1 ();
    serial_bit_feeder_if #(.WIDTH(W)) bus2 ();

    assign bus0.din = din_a[0];  assign bus0.din_valid = dv_a[0];  assign rdy[0] = bus0.din_ready;
    assign bus1.din = din_a[1];  assign bus1.din_valid = dv_a[1];  assign rdy[1] = bus1.din_ready;
    assign bus2.din = din_a[2];  assign bus2.din_valid = dv_a[2];  assign rdy[2] = bus2.din_ready;

    serial_bit_feeder #(.WIDTH(W), .GAP(0), .MSB_FIRST(1'b1)) dut0 (
        .clk(clk), .rst(rst), .up(bus0.slave), .X(x_o[0]), .x_valid(xv_o[0]),
        .busy(busy_o[0]), .words_sent(ws_o[0]));
    serial_bit_feeder #(.WIDTH(W), .GAP(2), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst(rst), .up(bus1.slave), .X(x_o[1]), .x_valid(xv_o[1]),
        .busy(busy_o[1]), .words_sent(ws_o[1]));
    serial_bit_feeder #(.WIDTH(W), .GAP(0), .MSB_FIRST(1'b0)) dut2 (
        .clk(clk), .rst(rst), .up(bus2.slave), .X(x_o[2]), .x_valid(xv_o[2]),
        .busy(busy_o[2]), .words_sent(ws_o[2]));

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Ready unless a word is waiting whose first bit is not the current cycle.
    function automatic bit m_ready(input int i);
        for (int k = 1; k < mq[i].size(); k++) begin
            if (mq[i][k].first) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_edge();
        for (int i = 0; i < NI; i++) begin
            bit    acc;
            bit    b;
            slot_t s;
            if (rst) begin
                mq[i].delete();
                ws_m[i] = 8'd0;
            end else begin
                acc = dv_a[i] && m_ready(i);
                if (mq[i].size() > 0) begin
                    s = mq[i].pop_front();
                    if (s.last) ws_m[i] = ws_m[i] + 8'd1;
                end
                if (acc) begin
                    if (mq[i].size() == 0) mq[i].push_back('{x: 1'b0, v: 1'b0, first: 1'b0, last: 1'b0});
                    for (int j = 0; j < W; j++) begin
                        b = MSBF[i] ? din_a[i][W-1-j] : din_a[i][j];
                        mq[i].push_back('{x: b, v: 1'b1, first: (j == 0), last: (j == W - 1)});
                    end
                    for (int g = 0; g < GAPS[i]; g++) begin
                        mq[i].push_back('{x: 1'b0, v: 1'b0, first: 1'b0, last: 1'b0});
                    end
                end
            end
        end
    endtask

    task automatic compare();
        for (int i = 0; i < NI; i++) begin
            bit ex = (mq[i].size() > 0) ? mq[i][0].x : 1'b0;
            bit ev = (mq[i].size() > 0) ? mq[i][0].v : 1'b0;
            check($sformatf("X[%0d]", i), int'(x_o[i]), int'(ex));
            check($sformatf("x_valid[%0d]", i), int'(xv_o[i]), int'(ev));
            check($sformatf("din_ready[%0d]", i), int'(rdy[i]), int'(m_ready(i)));
            check($sformatf("busy[%0d]", i), int'(busy_o[i]), int'(mq[i].size() > 0));
            check($sformatf("words_sent[%0d]", i), int'(ws_o[i]), int'(ws_m[i]));
            if (xv_o[i] === 1'b1) begin
                logb[i].push_back(x_o[i]);
                logc[i].push_back(cyc);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        compare();
    endtask

    // Offers a word and holds it until the DUT takes it (din_valid stays high).
    task automatic push(input int i, input logic [W-1:0] w);
        bit taken = 1'b0;
        din_a[i] = w;
        dv_a[i]  = 1'b1;
        for (int n = 0; n < 200 && !taken; n++) begin
            taken = (rdy[i] === 1'b1);
            step();
        end
        check($sformatf("push_ack[%0d]", i), int'(taken), 1);
    endtask

    task automatic drain(input int i);
        dv_a[i] = 1'b0;
        for (int n = 0; n < 500 && mq[i].size() > 0; n++) step();
        check($sformatf("drain[%0d]", i), mq[i].size(), 0);
    endtask

    function automatic int collect(input int i, input int start, input int n);
        int v = 0;
        for (int k = 0; k < n; k++) begin
            v = (v << 1) | ((start + k < logb[i].size()) ? int'(logb[i][start + k]) : 0);
        end
        return v;
    endfunction

    initial begin
        int m;
        total = 0;
        bad   = 0;
        cyc   = 0;
        rst   = 1'b1;
        for (int i = 0; i < NI; i++) begin
            din_a[i] = '0;
            dv_a[i]  = 1'b0;
            ws_m[i]  = 8'd0;
        end
        repeat (3) step();
        rst = 1'b0;
        step();
        check("reset_words", int'(ws_o[0]), 0);
        check("reset_ready", int'(rdy[0]), 1);
        check("reset_busy", int'(busy_o[0]), 0);

        // Single word, MSB first
        m = logb[0].size();
        push(0, 8'hB2);
        drain(0);
        check("b2_bits", collect(0, m, 8), 32'hB2);
        check("b2_count", logb[0].size() - m, 8);
        check("b2_sent", int'(ws_o[0]), 1);

        // Back-to-back words, no gap: 16 contiguous valid cycles
        m = logb[0].size();
        push(0, 8'hFF);
        push(0, 8'h00);
        drain(0);
        check("ff00_bits", collect(0, m, 16), 32'hFF00);
        check("ff00_span", logc[0][m+15] - logc[0][m], 15);
        check("ff00_sent", int'(ws_o[0]), 3);

        // GAP=2: two idle cycles between the words
        m = logb[1].size();
        push(1, 8'hA5);
        push(1, 8'h5A);
        drain(1);
        check("gap_bits", collect(1, m, 16), 32'hA55A);
        check("gap_span", logc[1][m+15] - logc[1][m], 17);
        check("gap_sent", int'(ws_o[1]), 2);

        // Three words with din_valid held high throughout
        m = logb[0].size();
        push(0, 8'h11);
        push(0, 8'h22);
        push(0, 8'h33);
        drain(0);
        check("three_bits", collect(0, m, 24), 32'h112233);
        check("three_span", logc[0][m+23] - logc[0][m], 23);
        check("three_sent", int'(ws_o[0]), 6);

        // Reset during the 4th bit of C3 with a second word held
        m = logb[0].size();
        push(0, 8'hC3);
        push(0, 8'h77);
        dv_a[0] = 1'b0;
        for (int n = 0; n < 50 && (logb[0].size() - m) < 4; n++) step();
        check("pre_reset_bits", collect(0, m, 4), 4'hC);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_xvalid", int'(xv_o[0]), 0);
        check("rst_ready", int'(rdy[0]), 1);
        check("rst_sent", int'(ws_o[0]), 0);
        m = logb[0].size();
        push(0, 8'h9E);
        drain(0);
        check("post_rst_bits", collect(0, m, 8), 32'h9E);
        check("post_rst_sent", int'(ws_o[0]), 1);

        // Reset wins over a simultaneous offer, then 256 words wrap the counter
        din_a[0] = 8'h55;
        dv_a[0]  = 1'b1;
        rst      = 1'b1;
        step();
        rst     = 1'b0;
        dv_a[0] = 1'b0;
        check("rst_prio_busy", int'(busy_o[0]), 0);
        check("rst_prio_ready", int'(rdy[0]), 1);
        for (int w = 0; w < 255; w++) push(0, 8'(w));
        drain(0);
        check("wrap_255", int'(ws_o[0]), 255);
        push(0, 8'hE7);
        drain(0);
        check("wrap_0", int'(ws_o[0]), 0);

        // LSB first
        m = logb[2].size();
        push(2, 8'h01);
        drain(2);
        check("lsb_01_bits", collect(2, m, 8), 32'h80);
        m = logb[2].size();
        push(2, 8'hB2);
        drain(2);
        check("lsb_b2_bits", collect(2, m, 8), 32'h4D);
        check("lsb_sent", int'(ws_o[2]), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_bit_feeder.md
SERIAL_BIT_FEEDER -- requirements
Module: serial_bit_feeder

Interface
REQ-001 Parameter WIDTH, default 8: bits per parallel word, range 2..32.
REQ-002 Parameter GAP, default 0: idle cycles inserted between consecutive words, range 0..15.
REQ-003 Parameter MSB_FIRST, default 1: 1 = word serialized MSB first, 0 = LSB first.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 din  input  WIDTH  parallel word to serialize.
REQ-007 din_valid  input  1  din holds a word to transfer.
REQ-008 din_ready  output  1  block can accept a word this cycle.
REQ-009 X  output  1  serial bit stream, feeds the downstream sequence-detector FSM X input.
REQ-010 x_valid  output  1  X carries a payload bit this cycle.
REQ-011 busy  output  1  shift or gap in progress, or holding register full.
REQ-012 words_sent  output  8  count of fully serialized words, modulo 256.

Function
REQ-013 Word accepted on rising edge where din_valid=1 and din_ready=1; din captured into holding register, hold_full set.
REQ-014 din_ready SHALL equal NOT hold_full, driven directly from a register (no combinational path from din_valid).
REQ-015 States: IDLE, SHIFT, GAP; one-hot or binary encoding is implementer's choice.
REQ-016 IDLE: x_valid=0, X=0; if hold_full, next edge transfers hold to shift register, clears hold_full, bit_cnt=0, goes to SHIFT.
REQ-017 SHIFT: x_valid=1, X = current bit (MSB or LSB per MSB_FIRST); each edge advances one bit, bit_cnt increments.
REQ-018 On edge with bit_cnt=WIDTH-1 in SHIFT: words_sent increments; if GAP>0 go to GAP; else if hold_full reload and stay SHIFT (contiguous bits); else go to IDLE.
REQ-019 GAP: x_valid=0, X=0 for exactly GAP cycles; then to SHIFT with reload if hold_full, else IDLE.
REQ-020 Latency: word accepted at edge k appears as first valid bit in cycle after edge k+1 when state was IDLE.
REQ-021 Holding register may be refilled during SHIFT/GAP; same-edge transfer out and acceptance in cannot occur since din_ready is low while hold_full.
REQ-022 din_valid with din_ready=0 SHALL have no effect; upstream must hold data.
REQ-023 words_sent wraps 255 -> 0 without flag.
REQ-024 X SHALL be 0 whenever x_valid=0.

Reset
REQ-025 rst=1 at an edge: state=IDLE, hold_full=0, shift register=0, bit_cnt=0, words_sent=0.
REQ-026 Outputs after reset: din_ready=1, X=0, x_valid=0, busy=0, words_sent=0.
REQ-027 Reset mid-word discards both shifted and held words; no partial word counted.
REQ-028 rst has priority over a simultaneous din acceptance.

Structure
REQ-029 State encodings and GAP/WIDTH range limits SHALL reside in a shared package used by the feeder and its bench.
REQ-030 One sub-module serial_shift_reg (parallel load, 1-bit shift, direction parameter) SHALL hold the datapath; FSM and counters in top.
REQ-031 Top-level port X SHALL connect directly to the X input of the downstream detector FSM without glue logic.

Verification
REQ-032 WIDTH=8, MSB_FIRST=1: push 8'hB2 from idle -> x_valid high 8 cycles, X=1,0,1,1,0,0,1,0, words_sent=1.
REQ-033 GAP=0: push 8'hFF then 8'h00 back-to-back -> 16 contiguous x_valid cycles, X eight 1s then eight 0s, words_sent=2.
REQ-034 GAP=2: push 8'hA5, 8'h5A -> exactly 2 cycles x_valid=0, X=0 between words.
REQ-035 Hold din_valid high with three words -> din_ready low while hold_full; all three serialized in order, none dropped or duplicated.
REQ-036 Assert rst at 4th bit of 8'hC3 with a word held -> next cycle x_valid=0, din_ready=1, words_sent=0, subsequent word serializes correctly.
REQ-037 Send 256 words -> words_sent returns to 0; MSB_FIRST=0 with 8'h01 -> X=1 then seven 0s.
